// File: rtl/cpu_types_pkg.sv
// Shared pipeline control types.
// Latch control bundle, sequencer states, register field type.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALTED
  } pipe_state_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic exmem_flush;
    logic memwb_en;
    logic memwb_flush;
  } latch_ctl_t;

  localparam latch_ctl_t CTL_IDLE = '0;

  function automatic latch_ctl_t ctl_go();
    latch_ctl_t c;
    c          = CTL_IDLE;
    c.pc_en    = 1'b1;
    c.ifid_en  = 1'b1;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    c.memwb_en = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and latch controls between datapath and sequencer.
// master = datapath side, slave = pipeline_ctrl.
interface pipeline_ctrl_if #(
  parameter int CNT_W = 16
);
  import cpu_types_pkg::*;

  logic             ihit;
  logic             dhit;
  logic             exmem_dREN;
  logic             exmem_dWEN;
  logic             idex_memread;
  regbits_t         idex_rt;
  regbits_t         ifid_rs;
  regbits_t         ifid_rt;
  logic             branch_taken;
  logic             exmem_halt;
  logic             memwb_halt;

  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             exmem_flush;
  logic             memwb_en;
  logic             memwb_flush;
  logic             halt;
  logic [CNT_W-1:0] stall_cnt;
  logic             dwait_err;

  modport master (
    output ihit, dhit, exmem_dREN, exmem_dWEN,
    output idex_memread, idex_rt, ifid_rs, ifid_rt,
    output branch_taken, exmem_halt, memwb_halt,
    input  pc_en, ifid_en, ifid_flush,
    input  idex_en, idex_flush,
    input  exmem_en, exmem_flush,
    input  memwb_en, memwb_flush,
    input  halt, stall_cnt, dwait_err
  );

  modport slave (
    input  ihit, dhit, exmem_dREN, exmem_dWEN,
    input  idex_memread, idex_rt, ifid_rs, ifid_rt,
    input  branch_taken, exmem_halt, memwb_halt,
    output pc_en, ifid_en, ifid_flush,
    output idex_en, idex_flush,
    output exmem_en, exmem_flush,
    output memwb_en, memwb_flush,
    output halt, stall_cnt, dwait_err
  );

endinterface

// File: rtl/hazard_detect.sv
// Load-use detector: load in ID/EX feeding a source of IF/ID.
// $zero never creates a dependency.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_memread,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  output logic     load_use
);

  logic hit_rs;
  logic hit_rt;

  assign hit_rs   = (idex_rt == ifid_rs);
  assign hit_rt   = (idex_rt == ifid_rt);
  assign load_use = idex_memread
                  && (idex_rt != '0)
                  && (hit_rs || hit_rt);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: latch en/flush, PC enable, halt drain,
// stall statistics and dmem wait watchdog.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W     = 16,
  parameter int DWAIT_MAX = 64
) (
  input logic           CLK,
  input logic           nRST,
  pipeline_ctrl_if.slave pif
);

  localparam int DW_W = $clog2(DWAIT_MAX + 2);

  pipe_state_t      state;
  pipe_state_t      state_n;
  latch_ctl_t       ctl;
  logic             mem_busy;
  logic             load_use;
  logic             s_busy;
  logic             s_br;
  logic             s_lu;
  logic             s_miss;
  logic             d_lu;
  logic             wait_cyc;
  logic [CNT_W-1:0] stall_cnt;
  logic [DW_W-1:0]  dwait_cnt;
  logic [DW_W-1:0]  dwait_inc;
  logic             dwait_err;

  hazard_detect u_hazard (
    .idex_memread (pif.idex_memread),
    .idex_rt      (pif.idex_rt),
    .ifid_rs      (pif.ifid_rs),
    .ifid_rt      (pif.ifid_rt),
    .load_use     (load_use)
  );

  assign mem_busy = (pif.exmem_dREN || pif.exmem_dWEN)
                  && !pif.dhit;

  // one-hot priority selects, highest first
  assign s_busy = mem_busy;
  assign s_br   = !mem_busy && pif.branch_taken;
  assign s_lu   = !mem_busy && !pif.branch_taken
                && load_use;
  assign s_miss = !mem_busy && !pif.branch_taken
                && !load_use && !pif.ihit;
  assign d_lu   = !mem_busy && load_use;

  always_comb begin
    ctl     = CTL_IDLE;
    state_n = state;
    unique case (state)
      RUN: begin
        if (pif.exmem_halt) state_n = DRAIN;
        unique case (1'b1)
          s_busy: begin
            ctl.memwb_flush = 1'b1;
          end
          s_br: begin
            ctl.pc_en      = pif.ihit;
            ctl.ifid_flush = 1'b1;
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
          end
          s_lu: begin
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
          end
          s_miss: begin
            ctl.ifid_flush = 1'b1;
            ctl.idex_en    = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
          end
          default: ctl = ctl_go();
        endcase
      end
      DRAIN: begin
        if (pif.memwb_halt) state_n = HALTED;
        ctl.ifid_flush = 1'b1;
        unique case (1'b1)
          s_busy: begin
            ctl.memwb_flush = 1'b1;
          end
          d_lu: begin
            ctl.idex_flush = 1'b1;
            ctl.exmem_en   = 1'b1;
            ctl.memwb_en   = 1'b1;
          end
          default: begin
            ctl.idex_en  = 1'b1;
            ctl.exmem_en = 1'b1;
            ctl.memwb_en = 1'b1;
          end
        endcase
      end
      HALTED: ctl = CTL_IDLE;
      default: ctl = CTL_IDLE;
    endcase
    // async reset must silence the latches immediately
    if (!nRST) ctl = CTL_IDLE;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= state_n;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
    end else if (state == RUN && !ctl.pc_en
                 && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign wait_cyc  = mem_busy && (state != HALTED);
  assign dwait_inc = dwait_cnt + 1'b1;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      dwait_cnt <= '0;
      dwait_err <= 1'b0;
    end else if (wait_cyc) begin
      if (dwait_cnt != '1) dwait_cnt <= dwait_inc;
      if (DWAIT_MAX != 0
          && dwait_inc == DW_W'(DWAIT_MAX))
        dwait_err <= 1'b1;
    end else begin
      dwait_cnt <= '0;
    end
  end

  assign pif.pc_en       = ctl.pc_en;
  assign pif.ifid_en     = ctl.ifid_en;
  assign pif.ifid_flush  = ctl.ifid_flush;
  assign pif.idex_en     = ctl.idex_en;
  assign pif.idex_flush  = ctl.idex_flush;
  assign pif.exmem_en    = ctl.exmem_en;
  assign pif.exmem_flush = ctl.exmem_flush;
  assign pif.memwb_en    = ctl.memwb_en;
  assign pif.memwb_flush = ctl.memwb_flush;
  assign pif.halt        = (state == HALTED);
  assign pif.stall_cnt   = stall_cnt;
  assign pif.dwait_err   = dwait_err;

endmodule
